// File: rtl/add_pkg.sv
// ============================================================================
// Module   : add_pkg
// Brief    : Shared nibble width and FSM state type for the serial adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package add_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_state_t;

endpackage

`default_nettype wire

// File: rtl/nibble_add4.sv
// ============================================================================
// Module   : nibble_add4
// Brief    : Combinational 4-bit ripple-carry adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nibble_add4
    import add_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_bit
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[NIB_W];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module   : nibble_serial_adder
// Brief    : Wide unsigned adder sequenced LSB-nibble-first through one
//            4-bit adder, with valid/ready handshakes on both sides.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nibble_serial_adder
    import add_pkg::*;
#(
    parameter int N_NIB = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NIB_W*N_NIB-1:0] in_a,
    input  logic [NIB_W*N_NIB-1:0] in_b,
    input  logic                   in_cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NIB_W*N_NIB-1:0] out_sum,
    output logic                   out_cout
);

    localparam int c_w     = NIB_W * N_NIB;
    localparam int c_idx_w = (N_NIB > 1) ? $clog2(N_NIB) : 1;
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(N_NIB - 1);

    add_state_t         r_state;
    logic [c_w-1:0]     r_a_sh;
    logic [c_w-1:0]     r_b_sh;
    logic [c_w-1:0]     r_sum_sh;
    logic               r_carry;
    logic [c_idx_w-1:0] r_idx;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [NIB_W-1:0]   w_nib_sum;
    logic               w_nib_cout;
    logic [c_w-1:0]     w_sum_next;

    nibble_add4 u_add4 (
        .a    (r_a_sh[NIB_W-1:0]),
        .b    (r_b_sh[NIB_W-1:0]),
        .cin  (r_carry),
        .s    (w_nib_sum),
        .cout (w_nib_cout)
    );

    // New nibble enters at the top; written as a shift/or so N_NIB=1 needs no empty slice.
    assign w_sum_next = (r_sum_sh >> NIB_W) | (c_w'(w_nib_sum) << (c_w - NIB_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a_sh     <= in_a;
                        r_b_sh     <= in_b;
                        r_carry    <= in_cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    r_sum_sh <= w_sum_next;
                    r_carry  <= w_nib_cout;
                    r_a_sh   <= r_a_sh >> NIB_W;
                    r_b_sh   <= r_b_sh >> NIB_W;
                    r_idx    <= r_idx + 1'b1;
                    if (r_idx == c_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_sum_sh;
    assign out_cout  = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module   : tb_nibble_serial_adder
// Brief    : Randomized self-checking bench against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_cout;

    logic        d1_in_valid = 1'b0;
    logic        d1_in_ready;
    logic [3:0]  d1_in_a = '0;
    logic [3:0]  d1_in_b = '0;
    logic        d1_in_cin = 1'b0;
    logic        d1_out_valid;
    logic        d1_out_ready = 1'b0;
    logic [3:0]  d1_out_sum;
    logic        d1_out_cout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.N_NIB(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
    );

    nibble_serial_adder #(.N_NIB(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .in_a(d1_in_a), .in_b(d1_in_b), .in_cin(d1_in_cin),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .out_sum(d1_out_sum), .out_cout(d1_out_cout)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation on the N_NIB=4 instance; expected result is plain wide addition.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input int hold);
        logic [16:0] exp;
        int n;
        exp = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("latency", n, 32'd4);
        check_eq("sum", {16'd0, out_sum}, {16'd0, exp[15:0]});
        check_eq("cout", {31'd0, out_cout}, {31'd0, exp[16]});
        if (hold > 0) begin
            in_valid = 1'b1;
            repeat (hold) tick();
            in_valid = 1'b0;
            check_eq("held_sum", {16'd0, out_sum}, {16'd0, exp[15:0]});
            check_eq("held_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check_eq("post_hs_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int n;
        bit seen;

        // Reset and release
        repeat (3) tick();
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_sum", {16'd0, out_sum}, 32'd0);
        check_eq("rst_cout", {31'd0, out_cout}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("rel_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rel_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rel_sum", {16'd0, out_sum}, 32'd0);

        // Single-nibble instance: 0xF + 0x1
        d1_in_a = 4'hF; d1_in_b = 4'h1; d1_in_cin = 1'b0; d1_in_valid = 1'b1;
        tick();
        d1_in_valid = 1'b0;
        n = 0;
        while (!d1_out_valid && n < 10) begin
            tick();
            n++;
        end
        check_eq("n1_latency", n, 32'd1);
        check_eq("n1_sum", {28'd0, d1_out_sum}, 32'd0);
        check_eq("n1_cout", {31'd0, d1_out_cout}, 32'd1);
        d1_out_ready = 1'b1;
        tick();
        d1_out_ready = 1'b0;
        check_eq("n1_ready", {31'd0, d1_in_ready}, 32'd1);

        // Directed vectors
        run_op(16'h1234, 16'h4321, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 2);

        // Backpressure while in_valid pulses
        while (!in_ready) tick();
        in_a = 16'h0F0F; in_b = 16'h00F1; in_cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("bp_sum0", {16'd0, out_sum}, 32'h1000);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~i[0];
            in_a = 16'($urandom); in_b = 16'($urandom);
            tick();
            check_eq("bp_sum", {16'd0, out_sum}, 32'h1000);
            check_eq("bp_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (out_valid || !in_ready) seen = 1'b1;
        end
        check_eq("bp_no_consume", {31'd0, seen}, 32'd0);
        check_eq("bp_hold_last", {16'd0, out_sum}, 32'h1000);

        // Reset mid-operation
        in_a = 16'hABCD; in_b = 16'h1111; in_cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        check_eq("mid_rst_sum", {16'd0, out_sum}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check_eq("mid_rst_no_valid", {31'd0, seen}, 32'd0);
        run_op(16'h00FF, 16'h0001, 1'b0, 0);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
